// File: rtl/hex_display_scan.sv
// Time-multiplexed 8-digit hex display driver with a frame-synchronous (tear-free) value update.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading-zero digits above digit 0.
module hex_display_scan #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value_i,
  input  logic        load_i,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic [7:0]  an_o,
  output logic [2:0]  digit_idx_o,
  output logic        frame_o
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;
  logic [31:0]   pending;
  logic [31:0]   shown;
  logic          tick;
  logic          boundary;
  logic [3:0]    nibble;
  logic          digit_blank;
  logic [6:0]    seg_next;
  logic [7:0]    an_next;

  assign tick     = (cnt == CNT_MAX);
  assign boundary = tick && (digit_idx_o == 3'd7);
  assign dp_o     = 1'b1;

  // Blanking and segment data are decoded from the current slot, then registered.
  always_comb begin
    nibble = shown[{digit_idx_o, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    digit_blank = (digit_idx_o != 3'd0) && ((shown >> {digit_idx_o, 2'b00}) == 32'd0);
`else
    digit_blank = 1'b0;
`endif
    if ((cnt == '0) || digit_blank) an_next = 8'hFF;
    else                            an_next = ~(8'd1 << digit_idx_o);
  end

  always_comb begin
    seg_next = 7'h7F;
    case (nibble)
      4'h0: seg_next = 7'b1000000;
      4'h1: seg_next = 7'b1111001;
      4'h2: seg_next = 7'b0100100;
      4'h3: seg_next = 7'b0110000;
      4'h4: seg_next = 7'b0011001;
      4'h5: seg_next = 7'b0010010;
      4'h6: seg_next = 7'b0000010;
      4'h7: seg_next = 7'b1111000;
      4'h8: seg_next = 7'b0000000;
      4'h9: seg_next = 7'b0010000;
      4'hA: seg_next = 7'b0001000;
      4'hB: seg_next = 7'b0000011;
      4'hC: seg_next = 7'b1000110;
      4'hD: seg_next = 7'b0100001;
      4'hE: seg_next = 7'b0000110;
      4'hF: seg_next = 7'b0001110;
      default: seg_next = 7'h7F;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt         <= '0;
      digit_idx_o <= 3'd0;
      frame_o     <= 1'b0;
      pending     <= 32'd0;
      shown       <= 32'd0;
      seg_o       <= 7'h7F;
      an_o        <= 8'hFF;
    end else begin
      cnt         <= tick ? '0 : cnt + CW'(1);
      if (tick) digit_idx_o <= digit_idx_o + 3'd1;
      frame_o     <= boundary;
      if (load_i) pending <= value_i;
      // A load landing exactly on the boundary is the newest value, so it bypasses pending.
      if (boundary) shown <= load_i ? value_i : pending;
      seg_o       <= seg_next;
      an_o        <= an_next;
    end
  end

endmodule

// File: tb/tb_hex_display_scan.sv
// Bench for hex_display_scan at SCAN_DIV=4: lit-slot scoreboard plus scan-timing checks.
module tb_hex_display_scan;

  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] value_i = 32'd0;
  logic        load_i = 1'b0;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [7:0]  an_o;
  logic [2:0]  digit_idx_o;
  logic        frame_o;

  int n_vec = 0;
  int n_bad = 0;
  int k = 0;
  logic [14:0] exp_q[$];

  hex_display_scan #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst(rst), .value_i(value_i), .load_i(load_i),
    .seg_o(seg_o), .dp_o(dp_o), .an_o(an_o),
    .digit_idx_o(digit_idx_o), .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  // Edges since reset release; k=n means the nth rising edge that saw rst=1.
  always @(posedge clk) begin
    if (!rst) k <= 0;
    else      k <= k + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (k=%0d)", name, act, exp, k);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // Each lit slot is visible for SCAN_DIV-1 cycles (the first cycle is blanked).
  task automatic push_frame(input logic [31:0] val, input int ndig);
    logic [31:0] sh;
    logic        lit;
    for (int d = 0; d < ndig; d++) begin
      sh = val >> (4 * d);
`ifdef LEADING_ZERO_BLANK_EN
      lit = (d == 0) || (sh != 32'd0);
`else
      lit = 1'b1;
`endif
      if (lit)
        for (int c = 0; c < SCAN_DIV - 1; c++)
          exp_q.push_back({~(8'd1 << d), seg_of(sh[3:0])});
    end
  endtask

  // Returns #1 after edge n-1, so inputs set next are sampled on edge n.
  task automatic goto_edge(input int n);
    int guard;
    guard = 0;
    while (k != n - 1 && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    check("goto_edge_timeout", (k == n - 1) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic load_at(input int n, input logic [31:0] v);
    goto_edge(n);
    value_i = v;
    load_i  = 1'b1;
    @(posedge clk); #1;
    load_i  = 1'b0;
  endtask

  // Monitor: every cycle with a lit digit must match the next expected slot entry.
  always @(negedge clk) begin
    logic [14:0] e;
    if (an_o != 8'hFF) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL lit_slot: unexpected an=%h seg=%b (k=%0d)", an_o, seg_o, k);
      end else begin
        e = exp_q.pop_front();
        if ({an_o, seg_o} !== e) begin
          n_bad++;
          $display("FAIL lit_slot: got an=%h seg=%b expected an=%h seg=%b (k=%0d)",
                   an_o, seg_o, e[14:7], e[6:0], k);
        end
      end
    end
  end

  // Scan timing: slot advance every SCAN_DIV edges, frame pulse every 8 slots, blank slot start.
  always @(negedge clk) begin
    if (rst && k >= 1) begin
      check("digit_idx", {29'd0, digit_idx_o}, 32'((k / SCAN_DIV) % 8));
      check("frame_o", {31'd0, frame_o}, (k % (8 * SCAN_DIV) == 0) ? 32'd1 : 32'd0);
      if (k % SCAN_DIV == 1) check("an_blank", {24'd0, an_o}, 32'hFF);
    end
  end

  initial begin
    #20000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached (k=%0d)", k);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_seg", {25'd0, seg_o}, 32'h7F);
    check("rst_an", {24'd0, an_o}, 32'hFF);
    check("rst_idx", {29'd0, digit_idx_o}, 32'd0);
    check("rst_frame", {31'd0, frame_o}, 32'd0);
    check("rst_dp", {31'd0, dp_o}, 32'd1);

    push_frame(32'd0, 8);
    push_frame(32'h89ABCDEF, 8);
    push_frame(32'h89ABCDEF, 8);
    push_frame(32'h2, 4);
    @(posedge clk); #1;
    rst = 1'b1;

    load_at(10, 32'h89ABCDEF);
    load_at(70, 32'h1);
    load_at(96, 32'h2);
    load_at(100, 32'hFFFFFFFF);

    // Mid-frame reset with a competing load held through it.
    goto_edge(113);
    rst     = 1'b0;
    load_i  = 1'b1;
    value_i = 32'h12345678;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check("seg1_drained", exp_q.size(), 32'd0);
    check("rst2_seg", {25'd0, seg_o}, 32'h7F);
    check("rst2_an", {24'd0, an_o}, 32'hFF);
    check("rst2_idx", {29'd0, digit_idx_o}, 32'd0);
    check("rst2_frame", {31'd0, frame_o}, 32'd0);
    push_frame(32'd0, 8);
    push_frame(32'd0, 8);
    push_frame(32'h000000A5, 8);
    push_frame(32'h000000A5, 8);
    load_i  = 1'b0;
    value_i = 32'd0;
    rst     = 1'b1;

    // Continuous load across the boundary: only the boundary-edge value is shown.
    goto_edge(50);
    load_i = 1'b1;
    for (int e = 50; e <= 64; e++) begin
      value_i = (e == 64) ? 32'h000000A5 : 32'h100 + 32'(e);
      @(posedge clk); #1;
    end
    load_i  = 1'b0;
    value_i = 32'd0;

    goto_edge(130);
    check("seg2_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hex_display_scan.md
HEX_DISPLAY_SCAN -- requirements
Module: hex_display_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clock cycles per digit slot; legal values are 2 or more.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have port value_i, input, 32 bits: the word to display, taken from the processor's register-file read port.
REQ-005 SHALL have port load_i, input, 1 bit: a single-cycle strobe that captures value_i.
REQ-006 SHALL have port seg_o, output, 7 bits: segments {g,f,e,d,c,b,a}, active-low.
REQ-007 SHALL have port dp_o, output, 1 bit: decimal point, active-low, tied to 1 (off).
REQ-008 SHALL have port an_o, output, 8 bits: digit enables, active-low; bit n selects nibble n of the displayed word.
REQ-009 SHALL have port digit_idx_o, output, 3 bits: index of the current digit slot.
REQ-010 SHALL have port frame_o, output, 1 bit: one-cycle pulse marking the end of a full 8-digit scan.

Function
REQ-011 SHALL hold two 32-bit registers: pending and shown.
REQ-012 SHALL set pending to value_i on any edge where load_i=1.
REQ-013 SHALL copy into shown only at the frame boundary, so no frame mixes two values (no tearing).
REQ-014 SHALL implement a prescaler that counts 0..SCAN_DIV-1, wraps to 0, and asserts tick at count SCAN_DIV-1.
REQ-015 SHALL increment digit_idx on tick, wrapping 7 to 0.
REQ-016 SHALL define the frame boundary as a tick while digit_idx=7; on that edge frame_o=1 for exactly one cycle.
REQ-017 SHALL load shown from value_i if load_i=1 on the frame-boundary edge, otherwise from pending (newest value wins).
REQ-018 SHALL register seg_o and an_o, updating 1 cycle after the digit_idx/prescaler state they decode.
REQ-019 SHALL drive an_o=8'hFF (blanking, anti-ghosting) when the prescaler is 0; otherwise an_o = ~(1<<digit_idx).
REQ-020 SHALL decode seg_o from shown[4*digit_idx+3 : 4*digit_idx] as standard hex:
- 0 -> 1000000, 1 -> 1111001, 2 -> 0100100, 3 -> 0110000
- 4 -> 0011001, 5 -> 0010010, 6 -> 0000010, 7 -> 1111000
- 8 -> 0000000, 9 -> 0010000, A -> 0001000, b -> 0000011
- C -> 1000110, d -> 0100001, E -> 0000110, F -> 0001110
REQ-021 SHALL treat continuous load_i=1 as a capture on every cycle; only the value present at the boundary reaches shown.

Reset
REQ-022 SHALL, on rst=0, set prescaler=0, digit_idx_o=0, frame_o=0, pending=0, shown=0, seg_o=7'h7F, an_o=8'hFF, dp_o=1.
REQ-023 SHALL let reset mid-frame discard pending and shown, with scanning restarting at digit 0 on the first edge after rst returns to 1.
REQ-024 SHALL give reset priority over load_i in the same cycle.

Configuration
REQ-025 SHALL, when LEADING_ZERO_BLANK_EN is defined, keep an_o=8'hFF for any digit n>0 where shown[31:4n] is zero; digit 0 is always lit.
REQ-026 SHALL, when LEADING_ZERO_BLANK_EN is undefined, light all 8 digits, including leading zeros.

Verification (SCAN_DIV=4)
REQ-027 SHALL verify reset: hold rst=0 for 3 cycles -> seg_o=7F, an_o=FF, digit_idx_o=0, frame_o=0.
REQ-028 SHALL verify scan timing: release reset -> digit_idx_o advances every 4 cycles; frame_o pulses every 32 cycles; an_o=FF on each slot's first cycle.
REQ-029 SHALL verify loading: load 32'h89ABCDEF mid-frame -> display unchanged until the next frame_o, then digit 0 shows 0001110 (F) and digit 7 shows 0000000 (8).
REQ-030 SHALL verify boundary priority: load 32'h1 then 32'h2, with the second load on the frame-boundary edge -> the next frame shows 2 on digit 0.
REQ-031 SHALL verify reset recovery: assert rst mid-frame after a load -> shown=0, and the scan restarts at digit 0.
REQ-032 SHALL verify the configuration option: with LEADING_ZERO_BLANK_EN, load 32'h00000A5 -> only an_o bits 0 and 1 ever go low; without it, all 8 bits go low in turn.
